// File: rtl/dispenser_pkg.sv
// Shared types and constants for the dispenser sequencer.
package dispenser_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_OPEN  = 2'd2
    } state_t;

    localparam int               COUNT_W   = 8;
    localparam logic [COUNT_W-1:0] COUNT_MAX = 8'd255;

endpackage

// File: rtl/tick_gen.sv
// Seconds prescaler: one-cycle tick every TICK_DIV cycles while run is high.
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int            PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc;

    // run comes from registered FSM state, so tick has no input-to-output path
    assign tick = run && (presc == LAST);

    // Free-run while active, wrap after the tick cycle, hold at zero when idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            presc <= '0;
        else if (!run || tick)
            presc <= '0;
        else
            presc <= presc + PW'(1);
    end

endmodule

// File: rtl/dispense_timer.sv
// Dispenser gate sequencer: counts a latched interval down in seconds ticks,
// then holds the gate open for OPEN_TICKS ticks, optionally repeating.
module dispense_timer
    import dispenser_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int OPEN_TICKS = 3,
    parameter int W          = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               auto_repeat,
    input  logic [W-1:0]       interval,
    output logic [W-1:0]       remaining,
    output logic               gate_open,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] dispense_count
);

    // A zero open time would make the gate phase meaningless; clamp to one tick
    localparam int            OT_EFF = (OPEN_TICKS < 1) ? 1 : OPEN_TICKS;
    localparam int            OW     = $clog2(OT_EFF + 1);
    localparam logic [OW-1:0] OT_LD  = OW'(OT_EFF);

    state_t               state, state_n;
    logic [W-1:0]         interval_q, interval_n;
    logic [W-1:0]         rem_n;
    logic [OW-1:0]        open_cnt, open_n;
    logic                 done_n;
    logic [COUNT_W-1:0]   cnt_n;
    logic                 run;
    logic                 tick;

    assign run       = (state != S_IDLE);
    assign busy      = run;
    assign gate_open = (state == S_OPEN);

    // Prescaler is never cleared between phases, so every phase is whole ticks
    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .tick  (tick)
    );

    // Next-state and next-register values; stop overrides everything
    always_comb begin
        state_n    = state;
        interval_n = interval_q;
        rem_n      = remaining;
        open_n     = open_cnt;
        cnt_n      = dispense_count;
        done_n     = 1'b0;
        if (stop) begin
            state_n = S_IDLE;
            rem_n   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        interval_n = interval;
                        if (interval != '0) begin
                            rem_n   = interval;
                            state_n = S_COUNT;
                        end else begin
                            rem_n   = '0;
                            open_n  = OT_LD;
                            state_n = S_OPEN;
                        end
                    end
                end
                S_COUNT: begin
                    if (tick) begin
                        if (remaining == W'(1)) begin
                            rem_n   = '0;
                            open_n  = OT_LD;
                            state_n = S_OPEN;
                        end else begin
                            rem_n = remaining - W'(1);
                        end
                    end
                end
                S_OPEN: begin
                    if (tick) begin
                        if (open_cnt > OW'(1)) begin
                            open_n = open_cnt - OW'(1);
                        end else begin
                            // end of dispense: done shows in the cycle after this edge
                            done_n = 1'b1;
                            if (dispense_count != COUNT_MAX)
                                cnt_n = dispense_count + COUNT_W'(1);
                            if (!auto_repeat) begin
                                state_n = S_IDLE;
                            end else if (interval_q != '0) begin
                                rem_n   = interval_q;
                                state_n = S_COUNT;
                            end else begin
                                // zero interval with repeat: gate stays high, done still pulses
                                open_n = OT_LD;
                            end
                        end
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            interval_q     <= '0;
            remaining      <= '0;
            open_cnt       <= '0;
            done           <= 1'b0;
            dispense_count <= '0;
        end else begin
            state          <= state_n;
            interval_q     <= interval_n;
            remaining      <= rem_n;
            open_cnt       <= open_n;
            done           <= done_n;
            dispense_count <= cnt_n;
        end
    end

endmodule

// File: tb/tb_dispense_timer.sv
// Self-checking bench for dispense_timer: elapsed-time model plus directed scenarios.
module tb_dispense_timer;

    localparam int TDA = 4;
    localparam int OTA = 2;
    localparam int TDB = 1;
    localparam int OTB = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    // instance A: TICK_DIV=4, OPEN_TICKS=2
    logic       start = 1'b0, stop = 1'b0, ar = 1'b0;
    logic [3:0] iv = '0;
    logic [3:0] rem_a;
    logic       gate_a, busy_a, done_a;
    logic [7:0] cnt_a;
    // instance B: TICK_DIV=1, OPEN_TICKS=1 (saturation run)
    logic       start_b = 1'b0, stop_b = 1'b0, ar_b = 1'b0;
    logic [3:0] iv_b = '0;
    logic [3:0] rem_b;
    logic       gate_b, busy_b, done_b;
    logic [7:0] cnt_b;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    dispense_timer #(.TICK_DIV(TDA), .OPEN_TICKS(OTA), .W(4)) dut_a (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .auto_repeat(ar),
        .interval(iv), .remaining(rem_a), .gate_open(gate_a), .busy(busy_a),
        .done(done_a), .dispense_count(cnt_a));

    dispense_timer #(.TICK_DIV(TDB), .OPEN_TICKS(OTB), .W(4)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .stop(stop_b), .auto_repeat(ar_b),
        .interval(iv_b), .remaining(rem_b), .gate_open(gate_b), .busy(busy_b),
        .done(done_b), .dispense_count(cnt_b));

    // Model: phase (0 idle, 1 counting, 2 gate open) and cycles elapsed in it
    typedef struct {
        int mode;
        int el;
        int ivl;
        int cnt;
        bit done;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mstep(mdl_t m, bit st, bit sp, bit rep, int ivl, int td, int ot);
        mdl_t r = m;
        r.done = 1'b0;
        if (sp) begin
            r.mode = 0;
            r.el   = 0;
        end else begin
            case (m.mode)
                0: if (st) begin
                    r.ivl  = ivl;
                    r.el   = 0;
                    r.mode = (ivl != 0) ? 1 : 2;
                end
                1: begin
                    r.el = m.el + 1;
                    if (r.el == m.ivl * td) begin
                        r.mode = 2;
                        r.el   = 0;
                    end
                end
                default: begin
                    r.el = m.el + 1;
                    if (r.el == ot * td) begin
                        r.el   = 0;
                        r.done = 1'b1;
                        r.cnt  = (m.cnt < 255) ? m.cnt + 1 : 255;
                        r.mode = !rep ? 0 : ((m.ivl != 0) ? 1 : 2);
                    end
                end
            endcase
        end
        return r;
    endfunction

    function automatic int mrem(mdl_t m, int td);
        return (m.mode == 1) ? (m.ivl - m.el / td) : 0;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ma <= '{default: 0};
            mb <= '{default: 0};
        end else begin
            ma <= mstep(ma, start, stop, ar, int'(iv), TDA, OTA);
            mb <= mstep(mb, start_b, stop_b, ar_b, int'(iv_b), TDB, OTB);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("a.remaining", int'(rem_a), mrem(ma, TDA));
            chk("a.gate_open", int'(gate_a), int'(ma.mode == 2));
            chk("a.busy", int'(busy_a), int'(ma.mode != 0));
            chk("a.done", int'(done_a), int'(ma.done));
            chk("a.count", int'(cnt_a), ma.cnt);
            chk("b.remaining", int'(rem_b), mrem(mb, TDB));
            chk("b.gate_open", int'(gate_b), int'(mb.mode == 2));
            chk("b.done", int'(done_b), int'(mb.done));
            chk("b.count", int'(cnt_b), mb.cnt);
        end
    end

    bit rg[64];
    bit rd[64];
    int rr[64];

    // Issue a one-edge start on instance A; returns just after the start edge
    task automatic go(input int v);
        @(negedge clk);
        iv    = 4'(v);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Record A's outputs; index 0 is the cycle right after the start edge
    task automatic observe(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rg[i] = gate_a;
            rd[i] = done_a;
            rr[i] = int'(rem_a);
        end
    endtask

    function automatic int first_gate(input int n);
        for (int i = 0; i < n; i++) if (rg[i]) return i;
        return -1;
    endfunction

    function automatic int sum_gate(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += int'(rg[i]);
        return s;
    endfunction

    function automatic int sum_done(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += int'(rd[i]);
        return s;
    endfunction

    // Reference single run (interval 3): shared by the first and post-reset runs
    task automatic single_run(input string tag, input int exp_cnt);
        go(3);
        observe(24);
        chk({tag, " rem@0"}, rr[0], 3);
        chk({tag, " rem@3"}, rr[3], 3);
        chk({tag, " rem@4"}, rr[4], 2);
        chk({tag, " rem@8"}, rr[8], 1);
        chk({tag, " rem@12"}, rr[12], 0);
        chk({tag, " gate rise"}, first_gate(24), 12);
        chk({tag, " gate cycles"}, sum_gate(24), 8);
        chk({tag, " done pulses"}, sum_done(24), 1);
        chk({tag, " done@20"}, int'(rd[20]), 1);
        chk({tag, " count"}, int'(cnt_a), exp_cnt);
        chk({tag, " busy end"}, int'(busy_a), 0);
    endtask

    initial begin
        int rises, nd, nd_tail;
        repeat (3) @(negedge clk);
        chk("reset remaining", int'(rem_a), 0);
        chk("reset gate", int'(gate_a), 0);
        chk("reset busy", int'(busy_a), 0);
        chk("reset done", int'(done_a), 0);
        chk("reset count", int'(cnt_a), 0);
        reset  = 1'b1;
        chk_en = 1'b1;

        // single run
        single_run("run1", 1);

        // zero interval: gate opens the cycle after start
        go(0);
        observe(12);
        chk("zero gate rise", first_gate(12), 0);
        chk("zero gate cycles", sum_gate(12), 8);
        chk("zero done@8", int'(rd[8]), 1);
        chk("zero done pulses", sum_done(12), 1);
        nd = 0;
        for (int i = 0; i < 12; i++) if (rr[i] != 0) nd++;
        chk("zero remaining nonzero", nd, 0);
        chk("zero count", int'(cnt_a), 2);

        // stop in the third gate cycle
        go(1);
        repeat (7) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop mid gate", int'(gate_a), 0);
        chk("stop mid busy", int'(busy_a), 0);
        observe(8);
        chk("stop mid done", sum_done(8), 0);
        chk("stop mid count", int'(cnt_a), 2);

        // stop on the final open tick edge
        go(1);
        repeat (12) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop final gate", int'(gate_a), 0);
        chk("stop final done", int'(done_a), 0);
        observe(6);
        chk("stop final done later", sum_done(6), 0);
        chk("stop final count", int'(cnt_a), 2);

        // auto-repeat: three dispenses, extra starts and interval change ignored
        ar = 1'b1;
        go(2);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            rg[i] = gate_a;
            rd[i] = done_a;
            if (i == 5 || i == 20) start = 1'b1;
            if (i == 6 || i == 21) start = 1'b0;
            if (i == 10) iv = 4'd5;
            if (i == 40) ar = 1'b0;
        end
        rises = 0;
        for (int i = 1; i < 60; i++) if (rg[i] && !rg[i-1]) rises++;
        chk("repeat rises", rises, 3);
        chk("repeat rise1", int'(rg[8] && !rg[7]), 1);
        chk("repeat rise2", int'(rg[24] && !rg[23]), 1);
        chk("repeat rise3", int'(rg[40] && !rg[39]), 1);
        chk("repeat gate cycles", sum_gate(60), 24);
        chk("repeat done pulses", sum_done(60), 3);
        chk("repeat done@48", int'(rd[48]), 1);
        chk("repeat count", int'(cnt_a), 5);
        chk("repeat busy end", int'(busy_a), 0);

        // async reset between edges mid-count
        go(3);
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("areset remaining", int'(rem_a), 0);
        chk("areset busy", int'(busy_a), 0);
        chk("areset gate", int'(gate_a), 0);
        chk("areset done", int'(done_a), 0);
        chk("areset count", int'(cnt_a), 0);
        @(negedge clk);
        #2 reset = 1'b1;
        single_run("run2", 1);

        // saturation on instance B
        @(negedge clk);
        iv_b    = 4'd1;
        ar_b    = 1'b1;
        start_b = 1'b1;
        @(posedge clk);
        #1 start_b = 1'b0;
        nd      = 0;
        nd_tail = 0;
        for (int i = 0; i < 640; i++) begin
            @(negedge clk);
            if (done_b) begin
                nd++;
                if (i >= 620) nd_tail++;
            end
        end
        chk("sat count", int'(cnt_b), 255);
        chk("sat done pulses", nd, 319);
        chk("sat done tail", nd_tail, 10);
        stop_b = 1'b1;
        @(negedge clk);
        stop_b = 1'b0;
        chk("sat stopped", int'(busy_b), 0);
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
